// File: rtl/async_fifo_pkg.sv
// Shared definitions for both pointer domains of the dual-clock FIFO.
package async_fifo_pkg;

  // Default FIFO depth exponent and the matching pointer width.
  localparam int DEF_ADDRSIZE = 4;
  localparam int PTR_W        = DEF_ADDRSIZE + 1;

  // Working width of the conversion helpers. Narrower values are passed
  // zero-extended; the upper zeros do not disturb either conversion, so one
  // function serves every pointer width.
  localparam int CONV_W = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or
// above it. Purely combinational; usable on either side of the FIFO.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // One XOR reduction per output bit over the Gray bits from that bit upwards.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block of the dual-clock FIFO. Advances the
// read pointer on accepted pops and derives empty, almost-empty, occupancy,
// sticky underflow and peak occupancy from the synchronised write pointer.
module rptr_empty_lvl
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int PEAK_EN  = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                uf_clr,
  input  logic                pk_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow,
  output logic [ADDRSIZE:0]   rpeak
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin;
  logic [PW-1:0] lvl_next;
  logic [PW-1:0] peak_next;
  logic          pop;
  logic          rempty_val;
  logic          arempty_val;
  logic          underflow_next;

  gray2bin_conv #(.W(PW)) u_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign raddr = rbin[ADDRSIZE-1:0];

  // Next pointer, occupancy and flag values; all arithmetic is modulo the
  // pointer width so pointer wrap needs no special handling.
  always_comb begin
    pop            = rinc & ~rempty;
    rbinnext       = rbin + {{(PW-1){1'b0}}, pop};
    rgraynext      = PW'(bin2gray(CONV_W'(rbinnext)));
    lvl_next       = wbin - rbinnext;
    rempty_val     = (rgraynext == rq2_wptr);
    arempty_val    = (lvl_next <= ae_thresh);
    underflow_next = runderflow;
    if (rinc & rempty) begin
      underflow_next = 1'b1;
    end else if (uf_clr) begin
      underflow_next = 1'b0;
    end
    peak_next = rpeak;
    if (PEAK_EN == 0) begin
      peak_next = '0;
    end else if (pk_clr) begin
      peak_next = lvl_next;
    end else if (lvl_next > rpeak) begin
      peak_next = lvl_next;
    end
  end

  // Register the pointer and every status output.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      arempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
      rpeak      <= '0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= rempty_val;
      arempty    <= arempty_val;
      rlevel     <= lvl_next;
      runderflow <= underflow_next;
      rpeak      <= peak_next;
    end
  end

endmodule
